dbus_uncached_bridge: RTL and testbench

- Converts one dbus_req_t transaction from the CPU data port into a single-beat cbus_req_t transaction, and returns the result as dbus_resp_t.
- Sits downstream of the CPU memory stage and upstream of the cbus arbiter/AXI adapter.
- Used for MMIO and uncached regions that bypass the data cache.
- Serves one outstanding transaction at a time, with a bounded response timeout.

---
 rtl/dbus_uncached_bridge.sv | 174 +++++++++++++++++
 tb/tb_dbus_uncached_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dbus_uncached_bridge.sv
// Uncached/MMIO bridge: one dbus request becomes one single-beat cbus transaction, with a response timeout.
// Optional posted writes are enabled with `define DBUS_BRIDGE_POSTED_WRITE_EN.

package dbus_bridge_pkg;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [2:0]  msize_t;
  typedef logic [7:0]  mlen_t;
  typedef logic [1:0]  axi_burst_type_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  localparam mlen_t MLEN1 = 8'd0;
  localparam axi_burst_type_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;
endpackage

module dbus_uncached_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       bus_err
);

`ifdef DBUS_BRIDGE_POSTED_WRITE_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE, POST} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST_CNT = LAST_INT[CW-1:0];

  state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  cbus_req_t  creq_n;
  dbus_resp_t dresp_n;
  logic       bus_err_n;
  logic       beat_done;
  logic       expired;

  // Every output is a flop so nothing from dreq/cresp reaches an output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      creq    <= '0;
      dresp   <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      creq    <= creq_n;
      dresp   <= dresp_n;
      bus_err <= bus_err_n;
    end
  end

  // Next state plus next registered outputs; dresp pulses default to zero each cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    creq_n    = creq;
    dresp_n   = '0;
    bus_err_n = 1'b0;
    beat_done = cresp.ready && cresp.last;
    expired   = (TIMEOUT_CYCLES != 0) && (cnt == LAST_CNT);

    case (state)
      IDLE: begin
        if (dreq.valid) begin
          creq_n.valid    = 1'b1;
          creq_n.is_write = |dreq.strobe;
          creq_n.size     = dreq.size;
          creq_n.addr     = dreq.addr;
          creq_n.strobe   = dreq.strobe;
          creq_n.data     = dreq.data;
          creq_n.len      = MLEN1;
          creq_n.burst    = AXI_BURST_FIXED;
          cnt_n           = '0;
          dresp_n.addr_ok = 1'b1;
          state_n         = BUSY;
`ifdef DBUS_BRIDGE_POSTED_WRITE_EN
          if (|dreq.strobe) begin
            dresp_n.data_ok = 1'b1;
            state_n         = POST;
          end
`endif
        end
      end

      // A completing beat takes priority over a timeout firing on the same edge.
      BUSY: begin
        if (beat_done) begin
          creq_n          = '0;
          dresp_n.data_ok = 1'b1;
          dresp_n.data    = creq.is_write ? '0 : cresp.data;
          state_n         = DONE;
        end else if (expired) begin
          creq_n          = '0;
          dresp_n.data_ok = 1'b1;
          dresp_n.data    = '1;
          bus_err_n       = 1'b1;
          state_n         = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DONE: state_n = IDLE;

`ifdef DBUS_BRIDGE_POSTED_WRITE_EN
      // The CPU already has its data_ok, so completion here is silent apart from bus_err.
      POST: begin
        if (beat_done) begin
          creq_n  = '0;
          state_n = IDLE;
        end else if (expired) begin
          creq_n    = '0;
          bus_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Self-checking bench for dbus_uncached_bridge: directed cases plus randomized transactions
// checked against expectations built from the bridge's transaction rules.
module tb_dbus_uncached_bridge;
  import dbus_bridge_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_uncached_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .dreq   (dreq),
    .dresp  (dresp),
    .creq   (creq),
    .cresp  (cresp),
    .bus_err(bus_err)
  );

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One whole transaction from the CPU's view; latency 0 (or beyond the timeout) means cbus never answers.
  // Starts and ends on a falling edge; leaves dreq idle one cycle after data_ok.
  task automatic apply_stimulus(input addr_t addr, input msize_t size, input strobe_t strobe,
                                input word_t data, input int latency, input word_t rdata);
    dbus_req_t  r;
    cbus_req_t  exp_creq;
    dbus_resp_t exp_resp;
    logic       wr, timeout, posted, rb;
    int         n;

    wr      = |strobe;
    timeout = (latency == 0) || (latency > TO);
    n       = timeout ? TO : latency;
    posted  = 1'b0;
`ifdef DBUS_BRIDGE_POSTED_WRITE_EN
    posted  = wr;
`endif

    r = '0;
    r.valid = 1'b1; r.addr = addr; r.size = size; r.strobe = strobe; r.data = data;

    exp_creq = '0;
    exp_creq.valid = 1'b1; exp_creq.is_write = wr; exp_creq.size = size; exp_creq.addr = addr;
    exp_creq.strobe = strobe; exp_creq.data = data; exp_creq.len = MLEN1; exp_creq.burst = AXI_BURST_FIXED;

    dreq = r;
    @(negedge clk);
    exp_resp = '0;
    exp_resp.addr_ok = 1'b1;
    exp_resp.data_ok = posted;
    check_output("accept_dresp", 256'(dresp), 256'(exp_resp));
    check_output("accept_creq", 256'(creq), 256'(exp_creq));
    check_output("accept_bus_err", 256'(bus_err), 256'(1'b0));
    if (posted) dreq = '0;

    for (int c = 1; c <= n; c++) begin
      if (c > 1) begin
        check_output("busy_creq", 256'(creq), 256'(exp_creq));
        check_output("busy_dresp", 256'(dresp), 256'(0));
      end
      if (c == n && !timeout) begin
        cresp.ready = 1'b1; cresp.last = 1'b1; cresp.data = rdata;
      end else begin
        rb = 1'($urandom_range(0, 1));
        cresp.ready = rb; cresp.last = ~rb; cresp.data = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    cresp = '0;

    exp_resp = '0;
    if (!posted) begin
      exp_resp.data_ok = 1'b1;
      exp_resp.data    = timeout ? 64'hFFFF_FFFF_FFFF_FFFF : (wr ? 64'h0 : rdata);
    end
    check_output("done_dresp", 256'(dresp), 256'(exp_resp));
    check_output("done_creq", 256'(creq), 256'(0));
    check_output("done_bus_err", 256'(bus_err), 256'(timeout));

    if (!posted) begin
      // CPU still held the request through the data_ok cycle; it must not be taken again.
      @(negedge clk);
      check_output("no_reaccept_dresp", 256'(dresp), 256'(0));
      check_output("no_reaccept_creq_valid", 256'(creq.valid), 256'(1'b0));
      check_output("idle_bus_err", 256'(bus_err), 256'(1'b0));
      dreq = '0;
    end
  endtask

  initial begin
    dbus_req_t rd;
    int        lat, gap;
    strobe_t   stb;

    reset = 1'b1;
    dreq  = '0;
    cresp = '0;
    #1;
    check_output("reset_dresp", 256'(dresp), 256'(0));
    check_output("reset_creq", 256'(creq), 256'(0));
    check_output("reset_bus_err", 256'(bus_err), 256'(1'b0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] read, latency 3");
    apply_stimulus(64'h1000_0008, MSIZE8, 8'h00, 64'h0, 3, 64'hDEAD_BEEF_0000_1234);

    $display("[TB] byte write");
    apply_stimulus(64'h1000_01F2, MSIZE1, 8'b0000_0100, 64'h0000_0000_00CD_0000, 2, 64'h1111_2222_3333_4444);

    $display("[TB] timeout, cbus never ready");
    apply_stimulus(64'h1FC0_0010, MSIZE4, 8'h00, 64'h0, 0, 64'h0);

    $display("[TB] ready arriving on the timeout edge");
    apply_stimulus(64'h1FC0_0020, MSIZE4, 8'h00, 64'h0, TO, 64'h0123_4567_89AB_CDEF);

    $display("[TB] back-to-back reads");
    apply_stimulus(64'h1000_0100, MSIZE8, 8'h00, 64'h0, 1, 64'hAAAA_0000_BBBB_0001);
    apply_stimulus(64'h1000_0108, MSIZE8, 8'h00, 64'h0, 1, 64'hAAAA_0000_BBBB_0002);

    $display("[TB] asynchronous reset during busy");
    rd = '0;
    rd.valid = 1'b1; rd.addr = 64'h1000_0200; rd.size = MSIZE8;
    dreq = rd;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_creq", 256'(creq), 256'(0));
    check_output("async_reset_dresp", 256'(dresp), 256'(0));
    check_output("async_reset_bus_err", 256'(bus_err), 256'(1'b0));
    dreq = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(64'h1000_0200, MSIZE8, 8'h00, 64'h0, 4, 64'hCAFE_F00D_1234_5678);

`ifdef DBUS_BRIDGE_POSTED_WRITE_EN
    $display("[TB] posted write followed by read");
    rd = '0;
    rd.valid = 1'b1; rd.addr = 64'h1000_0300; rd.size = MSIZE8; rd.strobe = 8'hFF; rd.data = 64'h5555_6666_7777_8888;
    dreq = rd;
    @(negedge clk);
    check_output("post_accept_addr_ok", 256'(dresp.addr_ok), 256'(1'b1));
    check_output("post_accept_data_ok", 256'(dresp.data_ok), 256'(1'b1));
    check_output("post_accept_is_write", 256'(creq.is_write), 256'(1'b1));
    rd = '0;
    rd.valid = 1'b1; rd.addr = 64'h1000_0308; rd.size = MSIZE8;
    dreq = rd;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) check_output("post_read_withheld", 256'(dresp), 256'(0));
      if (c == 5) begin
        cresp.ready = 1'b1; cresp.last = 1'b1;
      end
      @(negedge clk);
    end
    cresp = '0;
    check_output("post_done_creq", 256'(creq), 256'(0));
    check_output("post_done_dresp", 256'(dresp), 256'(0));
    apply_stimulus(64'h1000_0308, MSIZE8, 8'h00, 64'h0, 2, 64'h9999_AAAA_BBBB_CCCC);
`endif

    $display("[TB] randomized transactions");
    for (int i = 0; i < 24; i++) begin
      lat = $urandom_range(0, 6) == 0 ? 0 : $urandom_range(1, TO);
      stb = $urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(1, 255));
      apply_stimulus({$urandom, $urandom}, 3'($urandom_range(0, 3)), stb, {$urandom, $urandom},
                     lat, {$urandom, $urandom});
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
